digit_scan_mux: RTL and testbench

Time-multiplexed display scanner that succeeds the fixed 16-bit/4-digit nibble selector. It captures a packed multi-digit value into a tear-free shadow register and steps a digit index at a programmable refresh rate. Each cycle it drives the selected digit's code, a one-hot active-low digit enable and a blank flag, with optional leading-zero suppression. It sits between the value-producing logic and the seven-segment decoder and anode pins.

---
 rtl/digit_scan_mux.sv | 113 +++++++++++
 tb/tb_digit_scan_mux.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/digit_scan_mux.sv
// ============================================================================
// Module   : digit_scan_mux
// Purpose  : Time-multiplexed digit scanner with tear-free shadow capture,
//            programmable slot length and optional leading-zero blanking.
// Revision : 1.0
// ============================================================================
`default_nettype none

module digit_scan_mux #(
    parameter int DIGITS   = 4,
    parameter int NIB_W    = 4,
    parameter int DIV      = 100000,
    parameter int BLANK_LZ = 1,
    parameter int IDX_W    = $clog2(DIGITS)
) (
    input  logic                      clk,
    input  logic                      resetn,
    input  logic [DIGITS*NIB_W-1:0]   in,
    input  logic                      enable,
    output logic [NIB_W-1:0]          out,
    output logic [DIGITS-1:0]         an,
    output logic                      blank,
    output logic [IDX_W-1:0]          digit_idx,
    output logic                      frame_done
);

    localparam int               PRE_W   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(DIV - 1);
    localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(DIGITS - 1);

    logic [PRE_W-1:0]        pre_q, pre_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [DIGITS*NIB_W-1:0] shadow_q, shadow_d;
    logic                    lp_q, lp_d;
    logic                    wrap_q;

    logic                    tick;
    logic                    wrap;
    logic [DIGITS-1:0]       sup;
    logic                    zero_tail;

    logic [NIB_W-1:0]        out_d;
    logic [DIGITS-1:0]       an_d;
    logic                    blank_d;

    always_comb begin
        tick     = enable && (pre_q == PRE_MAX);
        wrap     = tick && (idx_q == IDX_MAX);
        pre_d    = pre_q;
        idx_d    = idx_q;
        shadow_d = shadow_q;
        lp_d     = lp_q;
        if (tick) begin
            pre_d = '0;
            idx_d = wrap ? '0 : idx_q + 1'b1;
        end else if (enable) begin
            pre_d = pre_q + 1'b1;
        end
        // Shadow only refreshes at frame boundaries so a frame never tears.
        if (enable && (lp_q || wrap)) begin
            shadow_d = in;
            lp_d     = 1'b0;
        end
    end

    // Digit k is a leading zero when it and every higher digit are zero.
    always_comb begin
        sup       = '0;
        zero_tail = 1'b1;
        for (int k = DIGITS - 1; k > 0; k--) begin
            zero_tail = zero_tail && (shadow_q[k*NIB_W +: NIB_W] == '0);
            sup[k]    = (BLANK_LZ != 0) && zero_tail;
        end
    end

    always_comb begin
        out_d = shadow_q[idx_q*NIB_W +: NIB_W];
        an_d  = '1;
        if (enable && !sup[idx_q]) begin
            an_d[idx_q] = 1'b0;
        end
        blank_d = &an_d;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pre_q      <= '0;
            idx_q      <= '0;
            shadow_q   <= '0;
            lp_q       <= 1'b1;
            wrap_q     <= 1'b0;
            out        <= '0;
            an         <= '1;
            blank      <= 1'b1;
            digit_idx  <= '0;
            frame_done <= 1'b0;
        end else begin
            pre_q      <= pre_d;
            idx_q      <= idx_d;
            shadow_q   <= shadow_d;
            lp_q       <= lp_d;
            wrap_q     <= wrap;
            out        <= out_d;
            an         <= an_d;
            blank      <= blank_d;
            digit_idx  <= idx_q;
            frame_done <= wrap_q;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_digit_scan_mux.sv
// ============================================================================
// Module   : tb_digit_scan_mux
// Purpose  : Directed self-checking bench for digit_scan_mux (DIV=4, 4 digits,
//            with and without leading-zero blanking).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_digit_scan_mux;

    logic        clk;
    logic        resetn;
    logic        enable;
    logic [15:0] in0, in1;

    logic [3:0]  out0, out1;
    logic [3:0]  an0, an1;
    logic        blank0, blank1;
    logic [1:0]  idx0, idx1;
    logic        fd0, fd1;

    int checks = 0;
    int errors = 0;

    digit_scan_mux #(.DIGITS(4), .NIB_W(4), .DIV(4), .BLANK_LZ(0)) dut0 (
        .clk(clk), .resetn(resetn), .in(in0), .enable(enable),
        .out(out0), .an(an0), .blank(blank0), .digit_idx(idx0), .frame_done(fd0)
    );

    digit_scan_mux #(.DIGITS(4), .NIB_W(4), .DIV(4), .BLANK_LZ(1)) dut1 (
        .clk(clk), .resetn(resetn), .in(in1), .enable(enable),
        .out(out1), .an(an1), .blank(blank1), .digit_idx(idx1), .frame_done(fd1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        resetn = 1'b0;
        enable = 1'b1;
        in0    = 16'h1234;
        in1    = 16'h0050;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out",   out0,   4'h0);
        chk("rst_an",    an0,    4'b1111);
        chk("rst_blank", blank0, 1'b1);
        chk("rst_idx",   idx0,   2'd0);
        chk("rst_fd",    fd0,    1'b0);

        @(negedge clk) resetn = 1'b1;

        // Edge 1: shadow still zero on the outputs, digit 0 lit.
        step(1);
        chk("e1_an",    an0,    4'b1110);
        chk("e1_blank", blank0, 1'b0);
        chk("e1_out",   out0,   4'h0);

        step(1);  // edge 2
        chk("e2_out",   out0, 4'h4);
        chk("e2_an",    an0,  4'b1110);
        chk("e2_idx",   idx0, 2'd0);
        chk("e2_lz_out", out1, 4'h0);
        chk("e2_lz_an",  an1,  4'b1110);

        step(3);  // edge 5
        chk("e5_out",   out0, 4'h3);
        chk("e5_an",    an0,  4'b1101);
        chk("e5_idx",   idx0, 2'd1);
        chk("e5_lz_out", out1, 4'h5);
        chk("e5_lz_an",  an1,  4'b1101);

        step(4);  // edge 9: digit 2 shown
        chk("e9_out",   out0, 4'h2);
        chk("e9_an",    an0,  4'b1011);
        chk("e9_lz_an",    an1,    4'b1111);
        chk("e9_lz_blank", blank1, 1'b1);
        chk("e9_lz_idx",   idx1,   2'd2);

        in0 = 16'hABCD;
        in1 = 16'h0000;

        step(4);  // edge 13: old frame continues
        chk("e13_out",  out0, 4'h1);
        chk("e13_an",   an0,  4'b0111);
        chk("e13_lz_blank", blank1, 1'b1);

        step(3);  // edge 16
        chk("e16_out", out0, 4'h1);
        chk("e16_fd",  fd0,  1'b0);

        step(1);  // edge 17: new frame with frame_done
        chk("e17_out", out0, 4'hD);
        chk("e17_an",  an0,  4'b1110);
        chk("e17_fd",  fd0,  1'b1);
        chk("e17_lz_an",  an1, 4'b1110);
        chk("e17_lz_out", out1, 4'h0);
        chk("e17_lz_fd",  fd1, 1'b1);

        step(1);  // edge 18
        chk("e18_fd",  fd0,  1'b0);
        chk("e18_out", out0, 4'hD);

        step(3);  // edge 21: digit 1
        chk("e21_out", out0, 4'hC);
        chk("e21_an",  an0,  4'b1101);
        chk("e21_lz_an",    an1,    4'b1111);
        chk("e21_lz_blank", blank1, 1'b1);

        step(1);  // edge 22: digit 1 has used two slots
        enable = 1'b0;

        step(1);  // edge 23: dark
        chk("dis_an",    an0,    4'b1111);
        chk("dis_blank", blank0, 1'b1);
        chk("dis_idx",   idx0,   2'd1);
        chk("dis_out",   out0,   4'hC);

        step(9);  // edge 32
        chk("dis_end_an",  an0,  4'b1111);
        chk("dis_end_idx", idx0, 2'd1);
        enable = 1'b1;

        step(1);  // edge 33
        chk("ren_an",  an0,  4'b1101);
        chk("ren_idx", idx0, 2'd1);

        step(1);  // edge 34: final slot of digit 1
        chk("ren2_idx", idx0, 2'd1);
        chk("ren2_out", out0, 4'hC);

        step(1);  // edge 35: digit 2
        chk("ren3_idx", idx0, 2'd2);
        chk("ren3_out", out0, 4'hB);
        chk("ren3_an",  an0,  4'b1011);

        #2;
        resetn = 1'b0;
        #1;
        chk("arst_out",   out0,   4'h0);
        chk("arst_an",    an0,    4'b1111);
        chk("arst_blank", blank0, 1'b1);
        chk("arst_idx",   idx0,   2'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
